// File: rtl/div_unit_ctrl_if.sv
// div_unit_ctrl_if: request, divider and response signals of the divide sequencer.
// The slave modport is the sequencer; the master modport is its surroundings
// (issue logic, iterative divider and result consumer).
interface div_unit_ctrl_if #(
  parameter int TAG_W = 5
);
  // Request from the issue logic
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       op;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [TAG_W-1:0] tag;
  logic             flush;

  // Iterative divider interface
  logic             div_start;
  logic             div_signed;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_ready;
  logic             div_done;
  logic [31:0]      div_quotient;
  logic [31:0]      div_remainder;

  // Tagged result towards writeback
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  // Status
  logic             busy;
  logic             dbz;

  modport slave (
    input  req_valid, op, a, b, tag, flush,
    input  div_ready, div_done, div_quotient, div_remainder,
    input  rsp_ready,
    output req_ready, div_start, div_signed, div_a, div_b,
    output rsp_valid, rsp_data, rsp_tag, busy, dbz
  );

  modport master (
    output req_valid, op, a, b, tag, flush,
    output div_ready, div_done, div_quotient, div_remainder,
    output rsp_ready,
    input  req_ready, div_start, div_signed, div_a, div_b,
    input  rsp_valid, rsp_data, rsp_tag, busy, dbz
  );
endinterface

// File: rtl/div_unit_ctrl.sv
// div_unit_ctrl: sequencer for the iterative 32-bit divider of the RV32IM EX stage.
// Takes DIV/DIVU/REM/REMU ops, answers divide-by-zero, signed overflow and repeat
// operand pairs (1-entry DIV/REM result cache) without the divider, otherwise runs
// the divider and returns the tagged result. A flush kills the op in flight.
module div_unit_ctrl #(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  div_unit_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic req_ready;
  logic accept;
  logic div_start;
  logic req_signed;
  logic is_dbz;
  logic is_ovf;
  logic cache_hit;
  logic shortcut;
  logic [31:0] shortcut_data;

  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [TAG_W-1:0] tag_q;
  logic             signed_q;
  logic             rem_sel_q;
  logic [31:0]      rsp_data_q;
  logic             dbz_q;

  logic        cache_valid;
  logic        cache_signed;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [31:0] cache_quo;
  logic [31:0] cache_rem;

  // Classification of the request currently offered; only meaningful on accept
  assign req_signed = ~bus.op[0];
  assign is_dbz     = (bus.b == 32'd0);
  assign is_ovf     = req_signed & (bus.a == 32'h8000_0000) & (bus.b == 32'hFFFF_FFFF);
  assign cache_hit  = CACHE_EN & cache_valid & (bus.a == cache_a) & (bus.b == cache_b) &
                      (req_signed == cache_signed);
  assign shortcut   = is_dbz | is_ovf | cache_hit;

  // Result of an op that resolves without the divider, in classification priority order
  always_comb begin
    shortcut_data = 32'd0;
    if (is_dbz) begin
      shortcut_data = bus.op[1] ? bus.a : 32'hFFFF_FFFF;
    end else if (is_ovf) begin
      shortcut_data = bus.op[1] ? 32'd0 : 32'h8000_0000;
    end else if (cache_hit) begin
      shortcut_data = bus.op[1] ? cache_rem : cache_quo;
    end
  end

  // State register; reset drops any op in flight straight back to IDLE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, request ready and divider start; flush takes precedence in every state
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset too, so every output reads 0 while i_rst is high
        req_ready = ~bus.flush & ~i_rst;
        if (bus.req_valid & req_ready) begin
          state_nxt = shortcut ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_start = bus.div_ready & ~bus.flush;
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (div_start) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_nxt = DRAIN;
        end else if (bus.div_done) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = bus.flush ? DRAIN : RESP;
      end
      RESP: begin
        if (bus.flush | bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // The killed divide must fully retire before a new op may start it again
        if (bus.div_ready & ~bus.div_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = (state == IDLE) & bus.req_valid & req_ready;

  // Request registers and the response word, loaded on accept or from the divider in CAPTURE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      tag_q      <= '0;
      signed_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
      rsp_data_q <= 32'd0;
      dbz_q      <= 1'b0;
    end else begin
      dbz_q <= accept & is_dbz;
      if (accept) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        tag_q     <= bus.tag;
        signed_q  <= req_signed;
        rem_sel_q <= bus.op[1];
        if (shortcut) begin
          rsp_data_q <= shortcut_data;
        end
      end
      if ((state == CAPTURE) & ~bus.flush) begin
        rsp_data_q <= rem_sel_q ? bus.div_remainder : bus.div_quotient;
      end
    end
  end

  // Result cache: only a completed divider run refills it, only reset invalidates it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_a      <= 32'd0;
      cache_b      <= 32'd0;
      cache_quo    <= 32'd0;
      cache_rem    <= 32'd0;
    end else if ((state == CAPTURE) & ~bus.flush) begin
      cache_valid  <= 1'b1;
      cache_signed <= signed_q;
      cache_a      <= a_q;
      cache_b      <= b_q;
      cache_quo    <= bus.div_quotient;
      cache_rem    <= bus.div_remainder;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.div_start  = div_start;
  assign bus.div_signed = signed_q;
  assign bus.div_a      = a_q;
  assign bus.div_b      = b_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.busy       = (state != IDLE);
  assign bus.dbz        = dbz_q;

endmodule

// File: tb/tb_div_unit_ctrl.sv
// tb_div_unit_ctrl: directed and randomized ops against a behavioural divide model,
// with a variable-latency iterative divider model attached to the divider port.
module tb_div_unit_ctrl;
  localparam int TAG_W = 5;

  logic i_clk;
  logic i_rst;
  int checks = 0;
  int errors = 0;

  div_unit_ctrl_if #(.TAG_W(TAG_W)) bus ();

  div_unit_ctrl #(.TAG_W(TAG_W), .CACHE_EN(1'b1)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // RISC-V quotient/remainder from plain 64-bit arithmetic (truncating division)
  function automatic logic [31:0] refQuot(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    return 32'(x / y);
  endfunction

  function automatic logic [31:0] refRem(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    if (b == 32'd0) return a;
    x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    return 32'(x % y);
  endfunction

  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[1] ? refRem(~op[0], a, b) : refQuot(~op[0], a, b);
  endfunction

  // Iterative divider model: busy divLat+1 cycles, done for one cycle, results valid the cycle after
  logic divBusy, divDoneQ, divHold, divSignedQ;
  int divCount, divLat;
  logic [31:0] divA, divB, quoQ, remQ;

  assign bus.div_ready     = ~divBusy & ~divDoneQ & ~divHold;
  assign bus.div_done      = divDoneQ;
  assign bus.div_quotient  = quoQ;
  assign bus.div_remainder = remQ;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      divBusy    <= 1'b0;
      divDoneQ   <= 1'b0;
      divCount   <= 0;
      divSignedQ <= 1'b0;
      divA       <= 32'd0;
      divB       <= 32'd0;
      quoQ       <= 32'd0;
      remQ       <= 32'd0;
    end else begin
      divDoneQ <= 1'b0;
      if (divDoneQ) begin
        quoQ <= refQuot(divSignedQ, divA, divB);
        remQ <= refRem(divSignedQ, divA, divB);
      end
      if (divBusy) begin
        if (divCount == 0) begin
          divBusy  <= 1'b0;
          divDoneQ <= 1'b1;
        end else begin
          divCount <= divCount - 1;
        end
      end else if (bus.div_start) begin
        divBusy    <= 1'b1;
        divCount   <= divLat;
        divA       <= bus.div_a;
        divB       <= bus.div_b;
        divSignedQ <= bus.div_signed;
      end
    end
  end

  // Event counters for divider starts and divide-by-zero pulses
  int startCount = 0;
  int dbzCount = 0;
  always @(posedge i_clk) begin
    if (bus.div_start) startCount <= startCount + 1;
    if (bus.dbz) dbzCount <= dbzCount + 1;
  end

  // Operand pair remembered by the last completed divider run
  bit mcValid = 1'b0;
  bit mcSigned = 1'b0;
  logic [31:0] mcA = 32'd0;
  logic [31:0] mcB = 32'd0;

  function automatic bit expectDivider(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = ~op[0];
    if (b == 32'd0) return 1'b0;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
    if (mcValid && mcA == a && mcB == b && mcSigned == sgn) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Offer one request and return just after the edge that accepted it
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag);
    bit taken;
    taken = 1'b0;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.tag = tag;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge i_clk);
      if (bus.req_ready) taken = 1'b1;
      @(posedge i_clk);
      #1;
    end
    bus.req_valid = 1'b0;
    checkOutput("accept", 32'(taken), 1);
  endtask

  // Cycles from the accept edge until rsp_valid is seen; 0 means it never came
  task automatic waitResponse(output int lat);
    lat = 0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      @(negedge i_clk);
      if (bus.rsp_valid) lat = i;
    end
    checkOutput("rsp_arrived", 32'(lat != 0), 1);
  endtask

  // Full op with immediate consumption, checked against the reference model
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    bit expDiv;
    int sb, db, lat;
    expDiv = expectDivider(op, a, b);
    sb = startCount;
    db = dbzCount;
    bus.rsp_ready = 1'b1;
    applyStimulus(op, a, b, tag);
    waitResponse(lat);
    checkOutput({name, "_data"}, bus.rsp_data, refResult(op, a, b));
    checkOutput({name, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
    checkOutput({name, "_reqrdy_in_resp"}, 32'(bus.req_ready), 0);
    checkOutput({name, "_starts"}, startCount - sb, 32'(expDiv));
    if (!expDiv) checkOutput({name, "_lat"}, lat, 1);
    @(posedge i_clk);
    #1;
    checkOutput({name, "_dbz"}, dbzCount - db, 32'(b == 32'd0));
    checkOutput({name, "_idle"}, 32'(bus.busy), 0);
    if (expDiv) begin
      mcValid = 1'b1;
      mcA = a;
      mcB = b;
      mcSigned = ~op[0];
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int sb, lat;
    bit found, sawValid, sawReady, drained, firstBusy, divIdle;
    logic [31:0] ra, rb, lastA, lastB;
    logic [1:0] rop;

    i_rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.op = 2'b00;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.tag = '0;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    divHold = 1'b0;
    divLat = 2;
    lastA = 32'd7;
    lastB = 32'd3;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 0);
    checkOutput("rst_rsp_data", bus.rsp_data, 0);
    checkOutput("rst_div_start", 32'(bus.div_start), 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("idle_req_ready", 32'(bus.req_ready), 1);
    @(posedge i_clk);
    #1;

    $display("[TB] signed divide then cached remainder");
    runOp("div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1);
    runOp("rem_hit", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2);

    $display("[TB] divide by zero");
    runOp("divu_z", 2'b01, 32'd100, 32'd0, 5'd3);
    runOp("remu_z", 2'b11, 32'd100, 32'd0, 5'd4);
    runOp("div_still_hit", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);

    $display("[TB] signed overflow");
    runOp("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    runOp("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);

    $display("[TB] response backpressure");
    sb = startCount;
    bus.rsp_ready = 1'b0;
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd7);
    waitResponse(lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_data", bus.rsp_data, 32'h5555_5555);
      checkOutput("hold_tag", 32'(bus.rsp_tag), 7);
      checkOutput("hold_req_ready", 32'(bus.req_ready), 0);
      checkOutput("hold_valid", 32'(bus.rsp_valid), 1);
      @(negedge i_clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("hold_released", 32'(bus.rsp_valid), 0);
    checkOutput("hold_starts", startCount - sb, 1);
    mcValid = 1'b1; mcA = 32'hFFFF_FFFF; mcB = 32'd3; mcSigned = 1'b0;

    $display("[TB] divider not ready during issue");
    sb = startCount;
    divHold = 1'b1;
    applyStimulus(2'b00, 32'd1000, 32'd7, 5'd4);
    repeat (3) @(negedge i_clk);
    checkOutput("issue_hold_starts", startCount - sb, 0);
    checkOutput("issue_hold_busy", 32'(bus.busy), 1);
    checkOutput("issue_hold_valid", 32'(bus.rsp_valid), 0);
    divHold = 1'b0;
    waitResponse(lat);
    checkOutput("issue_rel_data", bus.rsp_data, 32'd142);
    checkOutput("issue_rel_starts", startCount - sb, 1);
    @(posedge i_clk);
    #1;
    mcValid = 1'b1; mcA = 32'd1000; mcB = 32'd7; mcSigned = 1'b1;

    $display("[TB] flush while issuing");
    sb = startCount;
    divHold = 1'b1;
    applyStimulus(2'b01, 32'd50, 32'd6, 5'd5);
    @(negedge i_clk);
    checkOutput("fiss_busy", 32'(bus.busy), 1);
    divHold = 1'b0;
    bus.flush = 1'b1;
    @(posedge i_clk);
    #1;
    bus.flush = 1'b0;
    @(negedge i_clk);
    checkOutput("fiss_idle", 32'(bus.busy), 0);
    checkOutput("fiss_valid", 32'(bus.rsp_valid), 0);
    checkOutput("fiss_starts", startCount - sb, 0);

    $display("[TB] flush with request in idle");
    @(posedge i_clk);
    #1;
    bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd3; bus.tag = 5'd1;
    bus.req_valid = 1'b1;
    bus.flush = 1'b1;
    @(negedge i_clk);
    checkOutput("fidle_req_ready", 32'(bus.req_ready), 0);
    @(posedge i_clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge i_clk);
    checkOutput("fidle_busy", 32'(bus.busy), 0);
    @(posedge i_clk);
    #1;

    $display("[TB] flush during response");
    bus.rsp_ready = 1'b0;
    applyStimulus(2'b01, 32'd5, 32'd0, 5'd6);
    waitResponse(lat);
    bus.flush = 1'b1;
    @(posedge i_clk);
    #1;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    checkOutput("fresp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("fresp_busy", 32'(bus.busy), 0);

    $display("[TB] flush while divider runs");
    divLat = 6;
    sb = startCount;
    applyStimulus(2'b01, 32'd10, 32'd3, 5'd3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_clk);
      if (startCount != sb) found = 1'b1;
    end
    checkOutput("fwait_started", 32'(found), 1);
    bus.flush = 1'b1;
    @(posedge i_clk);
    #1;
    bus.flush = 1'b0;
    sawValid = 1'b0; sawReady = 1'b0; drained = 1'b0; divIdle = 1'b0; firstBusy = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      @(negedge i_clk);
      if (i == 0) firstBusy = bus.busy;
      if (bus.rsp_valid) sawValid = 1'b1;
      if (bus.busy) begin
        if (bus.req_ready) sawReady = 1'b1;
      end else begin
        drained = 1'b1;
        divIdle = ~divBusy & ~divDoneQ;
      end
    end
    checkOutput("drain_entered", 32'(firstBusy), 1);
    checkOutput("drain_done", 32'(drained), 1);
    checkOutput("drain_no_rsp", 32'(sawValid), 0);
    checkOutput("drain_no_ready", 32'(sawReady), 0);
    checkOutput("drain_div_idle", 32'(divIdle), 1);
    @(posedge i_clk);
    #1;
    runOp("after_flush", 2'b01, 32'd10, 32'd3, 5'd2);

    $display("[TB] randomized ops");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = lastA;
        2: ra = 32'($urandom_range(0, 100));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = lastB;
        3: rb = 32'($urandom_range(1, 20));
        4: rb = 32'd0 - 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rop = 2'($urandom_range(0, 3));
      divLat = $urandom_range(0, 5);
      runOp("rnd", rop, ra, rb, 5'($urandom_range(0, 31)));
      lastA = ra;
      lastB = rb;
    end

    $display("[TB] reset while divider runs");
    divLat = 8;
    sb = startCount;
    applyStimulus(2'b00, 32'd77, 32'd5, 5'd9);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_clk);
      if (startCount != sb) found = 1'b1;
    end
    checkOutput("rwait_started", 32'(found), 1);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("arst_busy", 32'(bus.busy), 0);
    checkOutput("arst_req_ready", 32'(bus.req_ready), 0);
    checkOutput("arst_div_start", 32'(bus.div_start), 0);
    checkOutput("arst_div_signed", 32'(bus.div_signed), 0);
    checkOutput("arst_div_a", bus.div_a, 0);
    checkOutput("arst_div_b", bus.div_b, 0);
    checkOutput("arst_rsp_data", bus.rsp_data, 0);
    checkOutput("arst_rsp_tag", 32'(bus.rsp_tag), 0);
    checkOutput("arst_dbz", 32'(bus.dbz), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    mcValid = 1'b0;
    divLat = 3;
    runOp("post_reset", 2'b00, 32'd20, 32'hFFFF_FFFC, 5'd11);
    checkOutput("post_reset_value", bus.rsp_data, 32'hFFFF_FFFB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
